pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush sequencer with cache-miss wait FSM
// Optional performance counters built only when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 1023,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rd_i,
  input  logic [4:0]       ifid_rs1_i,
  input  logic [4:0]       ifid_rs2_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_hit_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             mem_stall_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] lu_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] TMO = WW'(MEM_TIMEOUT);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            mem_err_q, mem_err_d;
  logic            load_use;
  logic            miss;
  logic            stall;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    stall      = 1'b0;
    load_use   = idex_memread_i && (idex_rd_i != 5'd0) &&
                 ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));
    miss       = (state_q == RUN) && mem_req_i && !mem_hit_i;

    case (state_q)
      RUN: begin
        if (miss) begin
          stall      = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (mem_ack_i) begin
          state_d = RUN;
        end else begin
          stall = 1'b1;
          if (wait_cnt_q != TMO) wait_cnt_d = wait_cnt_q + 1'b1;
          // error flags on the same edge that the wait counter reaches the limit
          if (wait_cnt_d == TMO) mem_err_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    mem_stall_o   = 1'b0;
    if (rst_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (stall) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      mem_stall_o  = 1'b1;
    end else if (load_use) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign mem_err_o = mem_err_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu_fire, br_fire;

  always_comb begin
    lu_fire     = idex_bubble_o && !rst_i;
    br_fire     = ifid_flush_o && !rst_i;
    stall_cnt_d = stall_cnt_q;
    lu_cnt_d    = lu_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (mem_stall_o && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (lu_fire && !(&lu_cnt_q))        lu_cnt_d    = lu_cnt_q + 1'b1;
    if (br_fire && !(&flush_cnt_q))     flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      lu_cnt_q    <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign lu_cnt_o    = lu_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign lu_cnt_o    = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
// Expected bits are {pc_write, ifid_write, ifid_flush, idex_bubble, mem_stall, mem_err}.
module tb_pipe_hazard_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          memread = 1'b0;
  logic [4:0]    rd = '0, rs1 = '0, rs2 = '0;
  logic          br = 1'b0, req = 1'b0, hit = 1'b0, ack = 1'b0;
  logic          pc_w, ifid_w, flush, bubble, stall, err;
  logic [CW-1:0] stall_cnt, lu_cnt, flush_cnt;

  int vec_cnt = 0;
  int bad_cnt = 0;
  int exp_stall = 0, exp_lu = 0, exp_flush = 0;

  logic [5:0] exp_q[$];
  string      name_q[$];

  localparam logic [5:0] E_RST  = 6'b001100;
  localparam logic [5:0] E_IDLE = 6'b110000;
  localparam logic [5:0] E_LU   = 6'b000100;
  localparam logic [5:0] E_BR   = 6'b111000;
  localparam logic [5:0] E_STL  = 6'b000010;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(8), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .idex_memread_i(memread), .idex_rd_i(rd), .ifid_rs1_i(rs1), .ifid_rs2_i(rs2),
    .branch_taken_i(br), .mem_req_i(req), .mem_hit_i(hit), .mem_ack_i(ack),
    .pc_write_o(pc_w), .ifid_write_o(ifid_w), .ifid_flush_o(flush),
    .idex_bubble_o(bubble), .mem_stall_o(stall), .mem_err_o(err),
    .stall_cnt_o(stall_cnt), .lu_cnt_o(lu_cnt), .flush_cnt_o(flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int sat(input int v);
    return (v > (1 << CW) - 1) ? (1 << CW) - 1 : v;
  endfunction

  task automatic apply(input logic r, input logic mr, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic b, input logic rq, input logic h,
                       input logic a, input logic [5:0] e, input string nm);
    @(posedge clk);
    #1;
    rst = r; memread = mr; rd = d; rs1 = s1; rs2 = s2;
    br = b; req = rq; hit = h; ack = a;
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (r) begin
      exp_stall = 0; exp_lu = 0; exp_flush = 0;
    end else begin
      if (e[1]) exp_stall++;
      if (e[2]) exp_lu++;
      if (e[3]) exp_flush++;
    end
  endtask

  task automatic idle(input logic [5:0] e, input string nm);
    apply(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, e, nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [5:0] e;
      logic [5:0] act;
      string      nm;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {pc_w, ifid_w, flush, bubble, stall, err};
      vec_cnt++;
      if (act !== e) begin
        bad_cnt++;
        $display("FAIL %s: got %b expected %b", nm, act, e);
      end
    end
  end

  initial begin
    // reset held two cycles, then defaults
    apply(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RST, "reset0");
    apply(1, 1, 5'd5, 5'd5, 5'd5, 1, 1, 0, 0, E_RST, "reset1");
    idle(E_IDLE, "post_reset_idle");

    // load-use hazards and branches
    apply(0, 1, 5'd5, 5'd0, 5'd5, 0, 0, 0, 0, E_LU,   "lu_rs2");
    apply(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_IDLE, "lu_rd0");
    apply(0, 1, 5'd7, 5'd7, 5'd3, 0, 0, 0, 0, E_LU,   "lu_rs1");
    apply(0, 0, 5'd7, 5'd7, 5'd7, 0, 0, 0, 0, E_IDLE, "no_memread");
    apply(0, 1, 5'd9, 5'd9, 5'd1, 1, 0, 0, 0, E_LU,   "lu_over_branch");
    apply(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, E_BR,   "branch_flush");
    apply(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 1, E_IDLE, "hit_ack_in_run");

    // miss at T, ack at T+4
    apply(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, E_STL, "miss_T");
    for (int k = 1; k <= 3; k++) idle(E_STL, "miss_wait");
    apply(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, E_IDLE, "miss_ack");
    apply(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, E_IDLE, "run_after_ack");

    // miss + load-use + branch together
    apply(0, 1, 5'd5, 5'd1, 5'd5, 1, 1, 0, 0, E_STL, "prio_miss");
    apply(0, 1, 5'd5, 5'd1, 5'd5, 1, 1, 0, 1, E_LU,  "prio_ack_lu");
    apply(0, 1, 5'd5, 5'd1, 5'd5, 1, 0, 0, 0, E_LU,  "prio_lu_again");
    apply(0, 0, 5'd5, 5'd1, 5'd5, 1, 0, 0, 0, E_BR,  "prio_branch");

    // timeout: err visible from the 9th MEM_WAIT cycle on
    apply(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, E_STL, "tmo_miss");
    for (int k = 1; k <= 11; k++) idle(E_STL | ((k >= 9) ? 6'b000001 : 6'b0), "tmo_wait");
    apply(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, E_IDLE | 6'b000001, "tmo_ack_sticky");
    idle(E_IDLE | 6'b000001, "tmo_sticky");
    apply(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RST | 6'b000001, "tmo_reset");
    idle(E_IDLE, "tmo_cleared");

    // 20 stall cycles for counter saturation, then one bubble and one flush
    apply(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, E_STL, "long_miss");
    for (int k = 1; k <= 19; k++) idle(E_STL | ((k >= 9) ? 6'b000001 : 6'b0), "long_wait");
    apply(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, E_IDLE | 6'b000001, "long_ack");
    apply(0, 1, 5'd4, 5'd4, 5'd0, 0, 0, 0, 0, E_LU | 6'b000001, "long_lu");
    apply(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, E_BR | 6'b000001, "long_branch");
    idle(E_IDLE | 6'b000001, "final_idle");

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    vec_cnt++;
    if (exp_q.size() != 0) begin
      bad_cnt++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    @(posedge clk);
    #2;
`ifdef PIPE_PERF_CNT_EN
    vec_cnt++;
    if (int'(stall_cnt) != sat(exp_stall)) begin
      bad_cnt++;
      $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, sat(exp_stall));
    end
    vec_cnt++;
    if (int'(lu_cnt) != sat(exp_lu)) begin
      bad_cnt++;
      $display("FAIL lu_cnt: got %0d expected %0d", lu_cnt, sat(exp_lu));
    end
    vec_cnt++;
    if (int'(flush_cnt) != sat(exp_flush)) begin
      bad_cnt++;
      $display("FAIL flush_cnt: got %0d expected %0d", flush_cnt, sat(exp_flush));
    end
`else
    vec_cnt++;
    if ({stall_cnt, lu_cnt, flush_cnt} !== '0) begin
      bad_cnt++;
      $display("FAIL counters_off: got %0d/%0d/%0d expected 0/0/0", stall_cnt, lu_cnt, flush_cnt);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, bad_cnt);
    $finish;
  end

endmodule
